// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: opcodes, ALU
// functions, mux selects, sequencer states and the control-word types.
package cpu_pkg;

   localparam int unsigned OP_BITS  = 6;
   localparam int unsigned ALU_BITS = 3;
   localparam int unsigned ST_BITS  = 3;

   // Opcodes (IR[5:0])
   localparam logic [OP_BITS-1:0] OP_CLA = 6'h01;
   localparam logic [OP_BITS-1:0] OP_COM = 6'h02;
   localparam logic [OP_BITS-1:0] OP_SHR = 6'h03;
   localparam logic [OP_BITS-1:0] OP_CSL = 6'h04;
   localparam logic [OP_BITS-1:0] OP_ADD = 6'h05;
   localparam logic [OP_BITS-1:0] OP_STA = 6'h06;
   localparam logic [OP_BITS-1:0] OP_LDA = 6'h07;
   localparam logic [OP_BITS-1:0] OP_JMP = 6'h08;
   localparam logic [OP_BITS-1:0] OP_STP = 6'h09;
   localparam logic [OP_BITS-1:0] OP_BAN = 6'h0A;

   // ALU functions
   localparam logic [ALU_BITS-1:0] ALU_PASS = 3'b000;
   localparam logic [ALU_BITS-1:0] ALU_CSL  = 3'b100;
   localparam logic [ALU_BITS-1:0] ALU_SHR  = 3'b101;
   localparam logic [ALU_BITS-1:0] ALU_COM  = 3'b110;

   // Datapath mux selects
   localparam logic [1:0] MUX_A = 2'b00;
   localparam logic [1:0] MUX_B = 2'b01;

   // Sequencer states
   localparam logic [ST_BITS-1:0] S_FETCH  = 3'd0;
   localparam logic [ST_BITS-1:0] S_DECODE = 3'd1;
   localparam logic [ST_BITS-1:0] S_EXEC   = 3'd2;
   localparam logic [ST_BITS-1:0] S_MEM    = 3'd3;
   localparam logic [ST_BITS-1:0] S_WB     = 3'd4;
   localparam logic [ST_BITS-1:0] S_HALT   = 3'd5;

   // Where DECODE sends an instruction
   typedef enum logic [2:0] {
      CLS_NOP  = 3'd0,
      CLS_EXEC = 3'd1,
      CLS_MEM  = 3'd2,
      CLS_STA  = 3'd3,
      CLS_HALT = 3'd4,
      CLS_TRAP = 3'd5
   } op_class_e;

   // Datapath control word for EXEC or WB; pc_wr_cond gates pc_wr on ACC sign
   typedef struct packed {
      logic                acc_wr_en;
      logic                acc_rst;
      logic                pc_wr_en;
      logic                pc_wr_cond;
      logic [ALU_BITS-1:0] alu_op;
      logic [1:0]          mux1_sel;
      logic [1:0]          mux2_sel;
      logic [1:0]          mux3_sel;
      logic [1:0]          mux4_sel;
   } dp_ctrl_t;

   // Registered sequencer outputs
   typedef struct packed {
      logic                mem_req;
      logic                mem_addr_sel;
      logic                mm_wr_en;
      logic                pc_wr_en;
      logic                acc_wr_en;
      logic                acc_rst;
      logic                halted;
      logic [ALU_BITS-1:0] alu_op;
      logic [1:0]          mux1_sel;
      logic [1:0]          mux2_sel;
      logic [1:0]          mux3_sel;
      logic [1:0]          mux4_sel;
   } ctrl_out_t;

   // Expand a datapath control word into the output set, resolving BAN
   function automatic ctrl_out_t dp_to_out(input dp_ctrl_t w, input logic neg);
      ctrl_out_t o;
      o           = '0;
      o.pc_wr_en  = w.pc_wr_en | (w.pc_wr_cond & neg);
      o.acc_wr_en = w.acc_wr_en;
      o.acc_rst   = w.acc_rst;
      o.alu_op    = w.alu_op;
      o.mux1_sel  = w.mux1_sel;
      o.mux2_sel  = w.mux2_sel;
      o.mux3_sel  = w.mux3_sel;
      o.mux4_sel  = w.mux4_sel;
      return o;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus EXEC and WB control
// words. With ILLEGAL_TRAP_EN defined, unknown opcodes are classed as traps;
// otherwise they decode as NOP.
module ctrl_decode
   import cpu_pkg::*;
#(
   parameter int unsigned OP_W = 6
) (
   input  logic [OP_W-1:0] op,
   output op_class_e       cls,
   output dp_ctrl_t        exec_word,
   output dp_ctrl_t        wb_word
);

   // Opcode table
   always_comb begin
      cls       = CLS_NOP;
      exec_word = '0;
      wb_word   = '0;
      case (op)
         OP_W'(OP_CLA): begin
            cls               = CLS_EXEC;
            exec_word.acc_rst = 1'b1;
         end
         OP_W'(OP_COM): begin
            cls                 = CLS_EXEC;
            exec_word.acc_wr_en = 1'b1;
            exec_word.alu_op    = ALU_COM;
            exec_word.mux1_sel  = MUX_B;
            exec_word.mux2_sel  = MUX_B;
         end
         OP_W'(OP_SHR): begin
            cls                 = CLS_EXEC;
            exec_word.acc_wr_en = 1'b1;
            exec_word.alu_op    = ALU_SHR;
            exec_word.mux1_sel  = MUX_B;
            exec_word.mux2_sel  = MUX_B;
         end
         OP_W'(OP_CSL): begin
            cls                 = CLS_EXEC;
            exec_word.acc_wr_en = 1'b1;
            exec_word.alu_op    = ALU_CSL;
            exec_word.mux1_sel  = MUX_B;
            exec_word.mux2_sel  = MUX_B;
         end
         OP_W'(OP_JMP): begin
            cls                = CLS_EXEC;
            exec_word.pc_wr_en = 1'b1;
         end
         OP_W'(OP_BAN): begin
            cls                  = CLS_EXEC;
            exec_word.pc_wr_cond = 1'b1;
            exec_word.mux3_sel   = MUX_B;
            exec_word.mux4_sel   = MUX_B;
         end
         OP_W'(OP_ADD): begin
            cls               = CLS_MEM;
            wb_word.acc_wr_en = 1'b1;
            wb_word.alu_op    = ALU_PASS;
            wb_word.mux1_sel  = MUX_B;
            wb_word.mux2_sel  = MUX_B;
         end
         OP_W'(OP_LDA): begin
            cls               = CLS_MEM;
            wb_word.acc_wr_en = 1'b1;
            wb_word.alu_op    = ALU_PASS;
            wb_word.mux1_sel  = MUX_A;
            wb_word.mux2_sel  = MUX_A;
         end
         OP_W'(OP_STA): cls = CLS_STA;
         OP_W'(OP_STP): cls = CLS_HALT;
         default: begin
`ifdef ILLEGAL_TRAP_EN
            cls = CLS_TRAP;
`else
            cls = CLS_NOP;
`endif
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the accumulator CPU. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, shares the memory port via req/ack and
// halts with a sticky bus error if a request waits TIMEOUT cycles.
// Optional macro ILLEGAL_TRAP_EN adds the trap output and halts on unknown
// opcodes. ir_ld/pc_inc follow mem_ack in the same cycle; all other outputs
// are registered from the next state.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned OP_W     = 6,
   parameter int unsigned ALU_OP_W = 3,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [OP_W-1:0]     ir_op,
   input  logic                acc_neg,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                mem_addr_sel,
   output logic                ir_ld,
   output logic                pc_inc,
   output logic                pc_wr_en,
   output logic                acc_wr_en,
   output logic                acc_rst,
   output logic                mm_wr_en,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [1:0]          mux1_sel,
   output logic [1:0]          mux2_sel,
   output logic [1:0]          mux3_sel,
   output logic [1:0]          mux4_sel,
   output logic                halted,
   output logic                bus_err
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                trap
`endif
);

   localparam logic        TIMEOUT_ON = (TIMEOUT != 0);
   localparam int unsigned CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_ON ? TIMEOUT - 1 : 0);

   logic [ST_BITS-1:0] state, state_d;
   ctrl_out_t          out_q, out_d;
   logic               bus_err_q, bus_err_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   op_class_e          cls;
   dp_ctrl_t           exec_word, wb_word;
   logic               ack_c, wait_c, timeout_c;
`ifdef ILLEGAL_TRAP_EN
   logic               trap_q, trap_d;
`endif

   ctrl_decode #(
      .OP_W (OP_W)
   ) u_decode (
      .op        (ir_op),
      .cls       (cls),
      .exec_word (exec_word),
      .wb_word   (wb_word)
   );

   // Handshake qualifiers: ack only counts while a request is outstanding
   assign ack_c     = out_q.mem_req & mem_ack;
   assign wait_c    = out_q.mem_req & ~mem_ack;
   assign timeout_c = TIMEOUT_ON & wait_c & (cnt == CNT_LAST);

   // Next state, timeout counter and next registered outputs
   always_comb begin
      state_d   = state;
      bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
      trap_d    = trap_q;
`endif
      out_d     = '0;

      case (state)
         S_FETCH: begin
            if (ack_c) begin
               state_d = S_DECODE;
            end else if (timeout_c) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (cls)
               CLS_EXEC: state_d = S_EXEC;
               CLS_MEM,
               CLS_STA:  state_d = S_MEM;
               CLS_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
               CLS_TRAP: begin
                  state_d = S_HALT;
                  trap_d  = 1'b1;
               end
`endif
               default:  state_d = S_FETCH;
            endcase
         end
         S_EXEC: state_d = S_FETCH;
         S_MEM: begin
            if (ack_c) begin
               state_d = (cls == CLS_STA) ? S_FETCH : S_WB;
            end else if (timeout_c) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end
         end
         S_WB: state_d = S_FETCH;
         S_HALT: begin
            if (start) begin
               state_d   = S_FETCH;
               bus_err_d = 1'b0;
`ifdef ILLEGAL_TRAP_EN
               trap_d    = 1'b0;
`endif
            end
         end
         default: state_d = S_FETCH;
      endcase

      cnt_d = (TIMEOUT_ON && wait_c && (state_d == state)) ? cnt + CNT_W'(1) : '0;

      case (state_d)
         S_FETCH: out_d.mem_req = 1'b1;
         S_EXEC:  out_d = dp_to_out(exec_word, acc_neg);
         S_MEM: begin
            out_d.mem_req      = 1'b1;
            out_d.mem_addr_sel = 1'b1;
            out_d.mm_wr_en     = (cls == CLS_STA);
         end
         S_WB:    out_d = dp_to_out(wb_word, acc_neg);
         S_HALT:  out_d.halted = 1'b1;
         default: out_d = '0;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         out_q     <= '0;
         bus_err_q <= 1'b0;
         cnt       <= '0;
`ifdef ILLEGAL_TRAP_EN
         trap_q    <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         out_q     <= out_d;
         bus_err_q <= bus_err_d;
         cnt       <= cnt_d;
`ifdef ILLEGAL_TRAP_EN
         trap_q    <= trap_d;
`endif
      end
   end

   // IR load and PC increment coincide with the fetch acknowledge
   assign ir_ld  = (state == S_FETCH) & ack_c;
   assign pc_inc = (state == S_FETCH) & ack_c;

   assign mem_req      = out_q.mem_req;
   assign mem_addr_sel = out_q.mem_addr_sel;
   assign pc_wr_en     = out_q.pc_wr_en;
   assign acc_wr_en    = out_q.acc_wr_en;
   assign acc_rst      = out_q.acc_rst;
   assign mm_wr_en     = out_q.mm_wr_en;
   assign alu_op       = ALU_OP_W'(out_q.alu_op);
   assign mux1_sel     = out_q.mux1_sel;
   assign mux2_sel     = out_q.mux2_sel;
   assign mux3_sel     = out_q.mux3_sel;
   assign mux4_sel     = out_q.mux4_sel;
   assign halted       = out_q.halted;
   assign bus_err      = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
   assign trap         = trap_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: random instruction stream with random memory
// wait states, compared cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 16;

   localparam logic [5:0] CLA = 6'h01;
   localparam logic [5:0] COM = 6'h02;
   localparam logic [5:0] SHR = 6'h03;
   localparam logic [5:0] CSL = 6'h04;
   localparam logic [5:0] ADD = 6'h05;
   localparam logic [5:0] STA = 6'h06;
   localparam logic [5:0] LDA = 6'h07;
   localparam logic [5:0] JMP = 6'h08;
   localparam logic [5:0] STP = 6'h09;
   localparam logic [5:0] BAN = 6'h0A;
   localparam logic [5:0] ILL = 6'h3F;

   typedef struct packed {
      logic       req;
      logic       sel;
      logic       ir_ld;
      logic       pc_inc;
      logic       pc_wr;
      logic       acc_wr;
      logic       acc_rst;
      logic       mm_wr;
      logic [2:0] alu;
      logic [1:0] m1;
      logic [1:0] m2;
      logic [1:0] m3;
      logic [1:0] m4;
      logic       halted;
      logic       bus_err;
      logic       trap;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] ir_op;
   logic       acc_neg;
   logic       mem_ack;
   logic       mem_req, mem_addr_sel, ir_ld, pc_inc, pc_wr_en, acc_wr_en;
   logic       acc_rst, mm_wr_en, halted, bus_err;
   logic [2:0] alu_op;
   logic [1:0] mux1_sel, mux2_sel, mux3_sel, mux4_sel;
`ifdef ILLEGAL_TRAP_EN
   logic       trap;
`endif

   int   checks = 0;
   int   errors = 0;
   logic exp_bus_err = 1'b0;

   multicycle_ctrl #(
      .OP_W     (6),
      .ALU_OP_W (3),
      .TIMEOUT  (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ir_op        (ir_op),
      .acc_neg      (acc_neg),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_addr_sel (mem_addr_sel),
      .ir_ld        (ir_ld),
      .pc_inc       (pc_inc),
      .pc_wr_en     (pc_wr_en),
      .acc_wr_en    (acc_wr_en),
      .acc_rst      (acc_rst),
      .mm_wr_en     (mm_wr_en),
      .alu_op       (alu_op),
      .mux1_sel     (mux1_sel),
      .mux2_sel     (mux2_sel),
      .mux3_sel     (mux3_sel),
      .mux4_sel     (mux4_sel),
      .halted       (halted),
      .bus_err      (bus_err)
`ifdef ILLEGAL_TRAP_EN
      ,
      .trap         (trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.req     = mem_req;
      o.sel     = mem_addr_sel;
      o.ir_ld   = ir_ld;
      o.pc_inc  = pc_inc;
      o.pc_wr   = pc_wr_en;
      o.acc_wr  = acc_wr_en;
      o.acc_rst = acc_rst;
      o.mm_wr   = mm_wr_en;
      o.alu     = alu_op;
      o.m1      = mux1_sel;
      o.m2      = mux2_sel;
      o.m3      = mux3_sel;
      o.m4      = mux4_sel;
      o.halted  = halted;
      o.bus_err = bus_err;
`ifdef ILLEGAL_TRAP_EN
      o.trap    = trap;
`else
      o.trap    = 1'b0;
`endif
      return o;
   endfunction

   function automatic obs_t idle();
      obs_t e;
      e         = '0;
      e.bus_err = exp_bus_err;
      return e;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs after the edge, then compare all outputs
   task automatic step(input obs_t e, input logic ack, input logic st, input logic r, input string tag);
      @(posedge clk);
      #1;
      mem_ack = ack;
      start   = st;
      rst     = r;
      #1;
      check_eq(tag, {10'd0, sample()}, {10'd0, e});
   endtask

   // HALT for n cycles, then one cycle with start; flags clear afterwards
   task automatic halt_phase(input logic tr, input int n);
      obs_t e;
      e        = idle();
      e.halted = 1'b1;
      e.trap   = tr;
      for (int i = 0; i < n; i++) step(e, rnd_bit(), 1'b0, 1'b0, "halt");
      step(e, rnd_bit(), 1'b1, 1'b0, "halt_start");
      exp_bus_err = 1'b0;
   endtask

   task automatic fetch_phase(input int fw);
      obs_t e;
      e     = idle();
      e.req = 1'b1;
      for (int i = 0; i < fw; i++) step(e, 1'b0, 1'b0, 1'b0, "fetch_wait");
      e.ir_ld  = 1'b1;
      e.pc_inc = 1'b1;
      step(e, 1'b1, 1'b0, 1'b0, "fetch_ack");
   endtask

   task automatic mem_phase(input logic sta, input int mw);
      obs_t e;
      e       = idle();
      e.req   = 1'b1;
      e.sel   = 1'b1;
      e.mm_wr = sta;
      for (int i = 0; i < mw; i++) step(e, 1'b0, 1'b0, 1'b0, "mem_wait");
      step(e, 1'b1, 1'b0, 1'b0, "mem_ack");
   endtask

   // Reference model: one instruction from its FETCH cycle to its last cycle
   task automatic run_instr(input logic [5:0] op, input logic neg, input int fw, input int mw);
      obs_t e;
      fetch_phase(fw);
      ir_op   = op;
      acc_neg = neg;
      step(idle(), rnd_bit(), 1'b0, 1'b0, "decode");
      e = idle();
      case (op)
         CLA: begin
            e.acc_rst = 1'b1;
            step(e, rnd_bit(), 1'b0, 1'b0, "exec_cla");
         end
         COM, SHR, CSL: begin
            e.acc_wr = 1'b1;
            e.m1     = 2'b01;
            e.m2     = 2'b01;
            e.alu    = (op == COM) ? 3'b110 : (op == SHR) ? 3'b101 : 3'b100;
            step(e, rnd_bit(), 1'b0, 1'b0, "exec_alu");
         end
         JMP: begin
            e.pc_wr = 1'b1;
            step(e, rnd_bit(), 1'b0, 1'b0, "exec_jmp");
         end
         BAN: begin
            e.pc_wr = neg;
            e.m3    = 2'b01;
            e.m4    = 2'b01;
            step(e, rnd_bit(), 1'b0, 1'b0, "exec_ban");
         end
         ADD, LDA, STA: begin
            mem_phase(op == STA, mw);
            if (op != STA) begin
               e        = idle();
               e.acc_wr = 1'b1;
               e.m1     = (op == ADD) ? 2'b01 : 2'b00;
               e.m2     = e.m1;
               step(e, rnd_bit(), 1'b0, 1'b0, "wb");
            end
         end
         STP: halt_phase(1'b0, 3);
         default: begin
`ifdef ILLEGAL_TRAP_EN
            halt_phase(1'b1, 3);
`endif
         end
      endcase
   endtask

   // Memory never acknowledges: TO waiting cycles then HALT with bus_err
   task automatic run_timeout(input logic in_mem);
      obs_t e;
      if (in_mem) begin
         fetch_phase(0);
         ir_op = LDA;
         step(idle(), rnd_bit(), 1'b0, 1'b0, "decode");
      end
      e     = idle();
      e.req = 1'b1;
      e.sel = in_mem;
      for (int i = 0; i < int'(TO); i++) step(e, 1'b0, 1'b0, 1'b0, "to_wait");
      exp_bus_err = 1'b1;
      halt_phase(1'b0, 2);
   endtask

   // Reset asserted while an STA operand request is outstanding
   task automatic reset_mid_mem();
      obs_t e;
      fetch_phase(1);
      ir_op = STA;
      step(idle(), 1'b0, 1'b0, 1'b0, "decode");
      e       = idle();
      e.req   = 1'b1;
      e.sel   = 1'b1;
      e.mm_wr = 1'b1;
      step(e, 1'b0, 1'b0, 1'b0, "mem_wait");
      step(e, 1'b0, 1'b0, 1'b1, "mem_rst_asserted");
      exp_bus_err = 1'b0;
      step('0, 1'b1, 1'b0, 1'b0, "rst_outputs_zero");
   endtask

   logic [5:0] op_tab [13];

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      ir_op   = 6'h00;
      acc_neg = 1'b0;
      mem_ack = 1'b0;
      op_tab  = '{CLA, COM, SHR, CSL, ADD, STA, LDA, JMP, BAN, STP, ILL, 6'h00, 6'h2B};

      step('0, 1'b0, 1'b0, 1'b1, "reset");
      step('0, 1'b1, 1'b0, 1'b1, "reset_ack_ignored");
      step('0, 1'b1, 1'b0, 1'b0, "reset_release");

      run_instr(LDA, 1'b0, 3, 3);
      run_instr(BAN, 1'b0, 0, 0);
      run_instr(BAN, 1'b1, 1, 0);
      run_instr(STA, 1'b0, 0, 2);
      run_instr(CLA, 1'b0, 0, 0);
      run_instr(COM, 1'b1, 2, 0);
      run_instr(SHR, 1'b0, 0, 0);
      run_instr(CSL, 1'b0, 0, 0);
      run_instr(JMP, 1'b0, 0, 0);
      run_instr(ADD, 1'b0, 0, 0);
      run_timeout(1'b0);
      run_timeout(1'b1);
      run_instr(LDA, 1'b0, int'(TO) - 1, int'(TO) - 1);
      run_instr(STP, 1'b0, 0, 0);
      reset_mid_mem();
      run_instr(ILL, 1'b0, 0, 0);
      run_instr(ADD, 1'b1, 1, 1);

      for (int n = 0; n < 250; n++) begin
         int fw, mw;
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) begin
            run_timeout(rnd_bit());
         end else begin
            run_instr(op_tab[$urandom_range(0, 12)], rnd_bit(), fw, mw);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
